ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named CLK and nRST as in the rest of the codebase (nRST=1 resets).
REQ-002 Ports SHALL be as follows (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- nRST  in  1  async reset, active-high
- en  in  1  advance stage; 0 = stall/hold
- flush  in  1  squash slot being loaded
- in_valid  in  1  EX holds a real instruction
- alu_out  in  32  ALU result
- alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags
- ovf_trap  in  1  instruction traps on overflow (add/sub, not addu/subu)
- pc  in  32  instruction PC
- rt_data  in  32  store data
- wsel  in  5  destination register
- regwen, dren, dwen, halt_in  in  1 each  control bits
- exc_ack  in  1  exception handled
- out_valid  out  1  MEM slot valid
- alu_out_q, rt_data_q, pc_q  out  32  latched data
- zero_q, neg_q  out  1  latched flags
- wsel_q  out  5  latched destination
- regwen_q, dren_q, dwen_q  out  1  gated controls
- halt_q  out  1  sticky halt
- exc_pending  out  1  overflow exception outstanding
- epc  out  32  PC of the trapping instruction

Function
REQ-003 Latency SHALL be one cycle: inputs present at a rising edge with en=1 appear on the _q outputs after that edge.
REQ-004 Internal state SHALL be RUN, EXC or HALTED.
REQ-005 Priority per edge SHALL be: reset > flush > HALTED > EXC > RUN.
REQ-006 flush=1 SHALL clear out_valid, regwen_q, dren_q and dwen_q regardless of en; data outputs hold; state is unchanged.
REQ-007 When en=0 and flush=0, all outputs and state SHALL hold.
REQ-008 RUN, en=1, in_valid=0: the edge SHALL load a bubble (out_valid=0, control outputs 0) and capture data as don't-care.
REQ-009 RUN, en=1, in_valid=1, no trap: the edge SHALL latch all data and controls unchanged, with out_valid=1.
REQ-010 A trap (in_valid & alu_overflow & ovf_trap, RUN, en=1) SHALL cause, on that edge:
- out_valid=1;
- regwen_q, dren_q, dwen_q forced to 0;
- halt_in ignored;
- epc<=pc, exc_pending<=1, state->EXC.
REQ-011 alu_overflow with ovf_trap=0 SHALL be ignored (normal latch).
REQ-012 In EXC, every en=1 edge SHALL load a bubble, and further overflows SHALL NOT overwrite epc.
REQ-013 exc_ack in EXC SHALL clear exc_pending and return to RUN on that edge, independent of en; the slot loaded on that edge is still a bubble.
REQ-014 exc_ack in RUN or HALTED SHALL be ignored.
REQ-015 In RUN, a valid halt_in latched with en=1 and no trap SHALL set halt_q=1, move to HALTED and load that instruction normally.
REQ-016 In HALTED, halt_q SHALL stay 1 until reset, and every en=1 edge SHALL load a bubble.
REQ-017 zero_q and neg_q SHALL be latched directly from the ALU flags and SHALL NOT be recomputed.

Reset
REQ-018 Reset SHALL asynchronously force:
- all outputs to 0, including epc, pc_q and data outputs;
- exc_pending=0, halt_q=0;
- state=RUN.
REQ-019 Reset asserted mid-EXC or mid-HALTED SHALL discard the pending exception or halt with no residual effect after release.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Normal latch: en=1, in_valid=1, alu_out=0x0000_0005, wsel=3, regwen=1 -> next cycle out_valid=1, alu_out_q=5, wsel_q=3, regwen_q=1.
- Trap: alu_overflow=1, ovf_trap=1, pc=0x0000_0040, regwen=1 -> regwen_q=0, exc_pending=1, epc=0x40; next two en=1 edges give out_valid=0; exc_ack with en=0 -> exc_pending=0; next valid instruction latches normally.
- Unsigned overflow: alu_overflow=1, ovf_trap=0, regwen=1 -> regwen_q=1, exc_pending=0.
- Stall versus flush: en=0 for 3 cycles -> outputs hold; then en=0 with flush=1 -> out_valid=0, dwen_q=0, alu_out_q unchanged.
- Halt: halt_in=1 valid -> halt_q=1; subsequent valid stores give dwen_q=0, out_valid=0; exc_ack has no effect; async nRST pulse mid-cycle -> halt_q=0 immediately.
- Trap with halt: alu_overflow=1, ovf_trap=1, halt_in=1 -> exc_pending=1, halt_q=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with stall, flush, sticky halt and
//               overflow-exception capture.
//
//   Ports
//     CLK          in   1   clock, rising edge
//     nRST         in   1   asynchronous reset, active-high (1 = reset)
//     en           in   1   advance stage; 0 = stall/hold
//     flush        in   1   squash the slot being loaded
//     in_valid     in   1   EX holds a real instruction
//     alu_out      in  32   ALU result
//     alu_zero     in   1   ALU zero flag
//     alu_negative in   1   ALU negative flag
//     alu_overflow in   1   ALU signed-overflow flag
//     ovf_trap     in   1   instruction traps on overflow (add/sub)
//     pc           in  32   instruction PC
//     rt_data      in  32   store data
//     wsel         in   5   destination register
//     regwen       in   1   register write enable
//     dren         in   1   data read enable
//     dwen         in   1   data write enable
//     halt_in      in   1   halt instruction
//     exc_ack      in   1   exception handled
//     out_valid    out  1   MEM slot valid
//     alu_out_q    out 32   latched ALU result
//     rt_data_q    out 32   latched store data
//     pc_q         out 32   latched PC
//     zero_q       out  1   latched zero flag
//     neg_q        out  1   latched negative flag
//     wsel_q       out  5   latched destination
//     regwen_q     out  1   gated register write enable
//     dren_q       out  1   gated data read enable
//     dwen_q       out  1   gated data write enable
//     halt_q       out  1   sticky halt
//     exc_pending  out  1   overflow exception outstanding
//     epc          out 32   PC of the trapping instruction
//
// Revision    : 1.0  initial release
// ============================================================================
module ex_mem_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    input  logic        ovf_trap,
    input  logic [31:0] pc,
    input  logic [31:0] rt_data,
    input  logic [4:0]  wsel,
    input  logic        regwen,
    input  logic        dren,
    input  logic        dwen,
    input  logic        halt_in,
    input  logic        exc_ack,
    output logic        out_valid,
    output logic [31:0] alu_out_q,
    output logic [31:0] rt_data_q,
    output logic [31:0] pc_q,
    output logic        zero_q,
    output logic        neg_q,
    output logic [4:0]  wsel_q,
    output logic        regwen_q,
    output logic        dren_q,
    output logic        dwen_q,
    output logic        halt_q,
    output logic        exc_pending,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_EXC    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_out_valid;
    logic [31:0] r_alu_out;
    logic [31:0] r_rt_data;
    logic [31:0] r_pc;
    logic        r_zero;
    logic        r_neg;
    logic [4:0]  r_wsel;
    logic        r_regwen;
    logic        r_dren;
    logic        r_dwen;
    logic [31:0] r_epc;

    // Slot decode for the current edge.
    logic        w_trap;      // valid signed overflow on a trapping op
    logic        w_load;      // slot advances this edge (no flush, en high)
    logic        w_run;       // only RUN accepts real instructions
    logic        w_pass;      // instruction passes with its controls intact
    logic        w_slot_vld;  // next out_valid when the slot advances

    always_comb begin
        w_trap     = in_valid & alu_overflow & ovf_trap;
        w_load     = en & ~flush;
        w_run      = (r_state == S_RUN);
        // A trapping instruction still occupies the slot (so MEM sees it),
        // but it must not write anything or halt the machine.
        w_slot_vld = w_run & in_valid;
        w_pass     = w_run & in_valid & ~w_trap;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Flush freezes the state; exc_ack leaves EXC
    // whether or not the stage advances.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (!flush) begin
            case (r_state)
                S_RUN: begin
                    if (en && w_trap) begin
                        w_state_next = S_EXC;
                    end else if (en && in_valid && halt_in) begin
                        w_state_next = S_HALTED;
                    end
                end
                S_EXC: begin
                    if (exc_ack) begin
                        w_state_next = S_RUN;
                    end
                end
                S_HALTED: begin
                    w_state_next = S_HALTED;
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot valid and gated controls: cleared by flush regardless of en,
    // hold on a stall, otherwise follow the slot decode.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_out_valid <= 1'b0;
            r_regwen    <= 1'b0;
            r_dren      <= 1'b0;
            r_dwen      <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_regwen    <= 1'b0;
            r_dren      <= 1'b0;
            r_dwen      <= 1'b0;
        end else if (en) begin
            r_out_valid <= w_slot_vld;
            r_regwen    <= w_pass & regwen;
            r_dren      <= w_pass & dren;
            r_dwen      <= w_pass & dwen;
        end
    end

    // ------------------------------------------------------------------
    // Data path. Captured on every advancing edge; for bubbles the values
    // are don't-care since out_valid and the controls are low. Flags are
    // taken straight from the ALU, never recomputed from the result.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_alu_out <= 32'd0;
            r_rt_data <= 32'd0;
            r_pc      <= 32'd0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_wsel    <= 5'd0;
        end else if (w_load) begin
            r_alu_out <= alu_out;
            r_rt_data <= rt_data;
            r_pc      <= pc;
            r_zero    <= alu_zero;
            r_neg     <= alu_negative;
            r_wsel    <= wsel;
        end
    end

    // ------------------------------------------------------------------
    // Exception PC: written only by the trap that enters EXC, so later
    // overflows while the exception is outstanding cannot overwrite it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_epc <= 32'd0;
        end else if (w_load && w_run && w_trap) begin
            r_epc <= pc;
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_out_q   = r_alu_out;
    assign rt_data_q   = r_rt_data;
    assign pc_q        = r_pc;
    assign zero_q      = r_zero;
    assign neg_q       = r_neg;
    assign wsel_q      = r_wsel;
    assign regwen_q    = r_regwen;
    assign dren_q      = r_dren;
    assign dwen_q      = r_dwen;
    assign epc         = r_epc;
    // Both status outputs are decoded from the state register, so they are
    // glitch-free and clear together with the state on reset.
    assign halt_q      = (r_state == S_HALTED);
    assign exc_pending = (r_state == S_EXC);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Self-checking bench for ex_mem_reg: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_reg;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en, flush, in_valid;
    logic [31:0] alu_out, pc, rt_data;
    logic        alu_zero, alu_negative, alu_overflow, ovf_trap;
    logic [4:0]  wsel;
    logic        regwen, dren, dwen, halt_in, exc_ack;
    logic        out_valid;
    logic [31:0] alu_out_q, rt_data_q, pc_q, epc;
    logic        zero_q, neg_q;
    logic [4:0]  wsel_q;
    logic        regwen_q, dren_q, dwen_q, halt_q, exc_pending;

    always #5 CLK = ~CLK;

    ex_mem_reg dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .en           (en),
        .flush        (flush),
        .in_valid     (in_valid),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .ovf_trap     (ovf_trap),
        .pc           (pc),
        .rt_data      (rt_data),
        .wsel         (wsel),
        .regwen       (regwen),
        .dren         (dren),
        .dwen         (dwen),
        .halt_in      (halt_in),
        .exc_ack      (exc_ack),
        .out_valid    (out_valid),
        .alu_out_q    (alu_out_q),
        .rt_data_q    (rt_data_q),
        .pc_q         (pc_q),
        .zero_q       (zero_q),
        .neg_q        (neg_q),
        .wsel_q       (wsel_q),
        .regwen_q     (regwen_q),
        .dren_q       (dren_q),
        .dwen_q       (dwen_q),
        .halt_q       (halt_q),
        .exc_pending  (exc_pending),
        .epc          (epc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Machine mode as two flags: an outstanding exception, or halted.
    bit          m_exc, m_halt;
    bit          m_valid, m_rw, m_dr, m_dw;
    bit          m_known;   // data outputs hold a real instruction (or reset)
    logic [31:0] m_alu, m_rt, m_pc, m_epc;
    logic [4:0]  m_wsel;
    bit          m_zero, m_neg;

    task automatic model_reset();
        m_exc = 0; m_halt = 0;
        m_valid = 0; m_rw = 0; m_dr = 0; m_dw = 0;
        m_known = 1;
        m_alu = 0; m_rt = 0; m_pc = 0; m_epc = 0; m_wsel = 0;
        m_zero = 0; m_neg = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_dr = 0; m_dw = 0;
        m_known = 0;
    endtask

    task automatic model_take_data();
        m_alu = alu_out; m_rt = rt_data; m_pc = pc; m_wsel = wsel;
        m_zero = alu_zero; m_neg = alu_negative;
        m_known = 1;
    endtask

    task automatic model_edge();
        bit trap;
        trap = in_valid && alu_overflow && ovf_trap;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_dr = 0; m_dw = 0;
        end else if (m_halt) begin
            if (en) model_bubble();
        end else if (m_exc) begin
            if (en) model_bubble();
            if (exc_ack) m_exc = 0;
        end else if (en) begin
            if (!in_valid) begin
                model_bubble();
            end else if (trap) begin
                model_take_data();
                m_valid = 1; m_rw = 0; m_dr = 0; m_dw = 0;
                m_epc = pc;
                m_exc = 1;
            end else begin
                model_take_data();
                m_valid = 1; m_rw = regwen; m_dr = dren; m_dw = dwen;
                if (halt_in) m_halt = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("regwen_q", {31'd0, regwen_q}, {31'd0, m_rw});
        chk("dren_q", {31'd0, dren_q}, {31'd0, m_dr});
        chk("dwen_q", {31'd0, dwen_q}, {31'd0, m_dw});
        chk("halt_q", {31'd0, halt_q}, {31'd0, m_halt});
        chk("exc_pending", {31'd0, exc_pending}, {31'd0, m_exc});
        chk("epc", epc, m_epc);
        if (m_known) begin
            chk("alu_out_q", alu_out_q, m_alu);
            chk("rt_data_q", rt_data_q, m_rt);
            chk("pc_q", pc_q, m_pc);
            chk("wsel_q", {27'd0, wsel_q}, {27'd0, m_wsel});
            chk("zero_q", {31'd0, zero_q}, {31'd0, m_zero});
            chk("neg_q", {31'd0, neg_q}, {31'd0, m_neg});
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and held through the
    // next one; outputs are checked 1 unit after that edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        en = 0; flush = 0; in_valid = 0;
        alu_out = $urandom; pc = $urandom; rt_data = $urandom;
        alu_zero = 0; alu_negative = 0; alu_overflow = 0; ovf_trap = 0;
        wsel = 5'($urandom); regwen = 0; dren = 0; dwen = 0;
        halt_in = 0; exc_ack = 0;
    endtask

    // Mid-cycle asynchronous reset pulse, clear of any clock edge.
    task automatic async_reset();
        #1 nRST = 1;
        #1;
        model_reset();
        check_all();
        #1 nRST = 0;
    endtask

    initial begin
        nRST = 1;
        idle();
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge CLK);
        #1 nRST = 0;

        // Normal latch
        idle(); en = 1; in_valid = 1; alu_out = 32'h5; wsel = 5'd3; regwen = 1;
        step();
        chk("norm_valid", {31'd0, out_valid}, 32'd1);
        chk("norm_alu", alu_out_q, 32'h5);
        chk("norm_wsel", {27'd0, wsel_q}, 32'd3);
        chk("norm_regwen", {31'd0, regwen_q}, 32'd1);

        // Trap
        idle(); en = 1; in_valid = 1; alu_overflow = 1; ovf_trap = 1;
        pc = 32'h40; regwen = 1;
        step();
        chk("trap_regwen", {31'd0, regwen_q}, 32'd0);
        chk("trap_exc", {31'd0, exc_pending}, 32'd1);
        chk("trap_epc", epc, 32'h40);
        idle(); en = 1; in_valid = 1; alu_overflow = 1; ovf_trap = 1; pc = 32'h80;
        step();
        chk("exc_bubble1", {31'd0, out_valid}, 32'd0);
        step();
        chk("exc_bubble2", {31'd0, out_valid}, 32'd0);
        chk("exc_epc_kept", epc, 32'h40);
        idle(); exc_ack = 1;
        step();
        chk("ack_clear", {31'd0, exc_pending}, 32'd0);
        idle(); en = 1; in_valid = 1; alu_out = 32'h9; wsel = 5'd7; regwen = 1;
        step();
        chk("post_ack_valid", {31'd0, out_valid}, 32'd1);
        chk("post_ack_regwen", {31'd0, regwen_q}, 32'd1);

        // Unsigned overflow
        idle(); en = 1; in_valid = 1; alu_overflow = 1; ovf_trap = 0; regwen = 1;
        step();
        chk("uovf_regwen", {31'd0, regwen_q}, 32'd1);
        chk("uovf_exc", {31'd0, exc_pending}, 32'd0);

        // Stall versus flush
        idle(); en = 1; in_valid = 1; dwen = 1; alu_out = 32'h1234;
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); in_valid = 1; dwen = 1;
            step();
        end
        chk("stall_alu", alu_out_q, 32'h1234);
        chk("stall_dwen", {31'd0, dwen_q}, 32'd1);
        idle(); flush = 1; in_valid = 1;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_dwen", {31'd0, dwen_q}, 32'd0);
        chk("flush_alu", alu_out_q, 32'h1234);

        // Halt
        idle(); en = 1; in_valid = 1; halt_in = 1;
        step();
        chk("halt_set", {31'd0, halt_q}, 32'd1);
        chk("halt_slot", {31'd0, out_valid}, 32'd1);
        idle(); en = 1; in_valid = 1; dwen = 1;
        step();
        chk("halt_dwen", {31'd0, dwen_q}, 32'd0);
        chk("halt_valid", {31'd0, out_valid}, 32'd0);
        idle(); en = 1; exc_ack = 1;
        step();
        chk("halt_ack_ign", {31'd0, halt_q}, 32'd1);
        async_reset();
        chk("halt_rst", {31'd0, halt_q}, 32'd0);

        // Trap with halt, then reset mid-EXC leaves no residue
        idle(); en = 1; in_valid = 1; alu_overflow = 1; ovf_trap = 1; halt_in = 1;
        step();
        chk("trap_halt_exc", {31'd0, exc_pending}, 32'd1);
        chk("trap_halt_halt", {31'd0, halt_q}, 32'd0);
        async_reset();
        idle(); en = 1; in_valid = 1; regwen = 1;
        step();
        chk("exc_rst_run", {31'd0, regwen_q}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) async_reset();
            en           = ($urandom_range(3) != 0);
            flush        = ($urandom_range(9) == 0);
            in_valid     = ($urandom_range(3) != 0);
            alu_out      = $urandom;
            pc           = $urandom;
            rt_data      = $urandom;
            wsel         = 5'($urandom);
            alu_zero     = 1'($urandom);
            alu_negative = 1'($urandom);
            alu_overflow = ($urandom_range(3) == 0);
            ovf_trap     = 1'($urandom);
            regwen       = 1'($urandom);
            dren         = 1'($urandom);
            dwen         = 1'($urandom);
            halt_in      = ($urandom_range(15) == 0);
            exc_ack      = ($urandom_range(5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
